// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/halt control for the five-stage pipeline registers.
// Optional performance counters are built when PIPECTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int DRAIN_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             exmem_branch_taken,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_halt,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             idex_WEN,
  output logic             exmem_WEN,
  output logic             memwb_WEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  localparam logic [1:0] DRAIN_MAX = 2'(DRAIN_DEPTH);

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       halt_q, halt_d;
  logic       dmem_wait, load_use, advancing, branch_fire;

  always_comb begin
    dmem_wait   = (exmem_MemRead | exmem_MemWrite) & ~dhit;
    load_use    = idex_MemRead & (idex_rt != 5'd0) &
                  ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    advancing   = ~RST & (state_q != ST_HALTED) & ~dmem_wait;
    branch_fire = advancing & exmem_branch_taken;
  end

  // Priority chain: each branch only overrides the fields its rule names.
  always_comb begin
    pc_WEN      = 1'b1;
    ifid_WEN    = 1'b1;
    idex_WEN    = 1'b1;
    exmem_WEN   = 1'b1;
    memwb_WEN   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (RST) begin
      {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN} = 5'b0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
    end else if (state_q == ST_HALTED || dmem_wait) begin
      {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN} = 5'b0;
    end else if (exmem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_WEN     = 1'b0;
      ifid_WEN   = 1'b0;
      idex_flush = 1'b1;
    end else if (state_q == ST_DRAIN) begin
      pc_WEN     = 1'b0;
      ifid_flush = 1'b1;
    end else if (!ihit) begin
      pc_WEN     = 1'b0;
      ifid_WEN   = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (advancing) begin
      case (state_q)
        ST_RUN: begin
          if (ifid_halt && !exmem_branch_taken && !load_use && ihit) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = 2'd1;
          end
        end
        ST_DRAIN: begin
          // A taken branch in MEM is older than the halt, so the halt is squashed.
          if (branch_fire) begin
            state_d     = ST_RUN;
            drain_cnt_d = 2'd0;
          end else if (drain_cnt_q == DRAIN_MAX) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
    halt_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_q      <= halt_d;
    end
  end

  assign halt = halt_q;

`ifdef PIPECTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (state_q != ST_HALTED) begin
      if (!pc_WEN) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (branch_fire) flush_events_d = flush_events_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int DEPTH = 3;
  localparam int CW    = 32;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, ex_mr, ex_mw, br, id_mr, hlt;
  logic [4:0] id_rt, rs, rt;
  logic pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [CW-1:0] stall_cycles, flush_events;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.DRAIN_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_MemRead(ex_mr), .exmem_MemWrite(ex_mw), .exmem_branch_taken(br),
    .idex_MemRead(id_mr), .idex_rt(id_rt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_halt(hlt), .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN),
    .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct packed {
    logic rst, ihit, dhit, mr, mw, br, id_mr, hlt;
    logic [4:0] id_rt, rs, rt;
  } stim_t;

  typedef struct {
    logic [8:0]    ctl;
    logic          halt;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  bit done     = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = halted.
  int     m_mode  = 0;
  int     m_cnt   = 0;
  bit     m_halt  = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1; s.dhit = 1'b1;
    s.id_rt = 5'd3; s.rs = 5'd1; s.rt = 5'd2;
    return s;
  endfunction

  // ctl bits: {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, memwb_f}
  function automatic exp_t model_step(stim_t s);
    exp_t e;
    logic [8:0] c;
    bit adv, lu;
    c   = 9'b1_1111_0000;
    adv = 0;
    lu  = s.id_mr && s.id_rt != 0 && (s.id_rt == s.rs || s.id_rt == s.rt);
    if (s.rst) c = 9'b0_0000_1111;
    else if (m_mode == 2) c = 9'b0;
    else if ((s.mr || s.mw) && !s.dhit) c = 9'b0;
    else begin
      adv = 1;
      if (s.br) begin c[8] = 1; c[3] = 1; c[2] = 1; c[1] = 1; end
      else if (lu) begin c[8] = 0; c[7] = 0; c[2] = 1; end
      else if (m_mode == 1) begin c[8] = 0; c[3] = 1; end
      else if (!s.ihit) begin c[8] = 0; c[7] = 0; c[2] = 1; end
    end
    e.ctl  = c;
    e.halt = m_halt;
`ifdef PIPECTRL_PERF_EN
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
`else
    e.stall = '0;
    e.flush = '0;
`endif
    e.cyc = cyc_no;
    if (s.rst) begin
      m_mode = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_mode != 2 && !c[8]) m_stall++;
      if (adv && s.br) m_flush++;
      if (adv) begin
        if (m_mode == 0) begin
          if (s.hlt && !s.br && !lu && s.ihit) begin m_mode = 1; m_cnt = 1; end
        end else if (m_mode == 1) begin
          if (s.br) begin m_mode = 0; m_cnt = 0; end
          else if (m_cnt == DEPTH) m_mode = 2;
          else m_cnt++;
        end
      end
    end
    m_halt = (m_mode == 2);
    return e;
  endfunction

  task automatic drive(stim_t s);
    @(posedge CLK);
    #1;
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; ex_mr = s.mr; ex_mw = s.mw;
    br = s.br; id_mr = s.id_mr; hlt = s.hlt; id_rt = s.id_rt; rs = s.rs; rt = s.rt;
    cyc_no++;
    exp_q.push_back(model_step(s));
  endtask

  task automatic check(string name, logic [CW-1:0] act, logic [CW-1:0] req, int cyc);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    logic [8:0] act;
    while (!done) begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
               ifid_flush, idex_flush, exmem_flush, memwb_flush};
        check("ctl", CW'(act), CW'(e.ctl), e.cyc);
        check("halt", CW'(halt), CW'(e.halt), e.cyc);
        check("stall_cycles", stall_cycles, e.stall, e.cyc);
        check("flush_events", flush_events, e.flush, e.cyc);
      end
    end
  end

  initial begin
    stim_t s;
    RST = 1; ihit = 1; dhit = 1; ex_mr = 0; ex_mw = 0; br = 0; id_mr = 0; hlt = 0;
    id_rt = 0; rs = 0; rt = 0;

    s = idle(); s.rst = 1;
    repeat (2) drive(s);
    repeat (2) drive(idle());
    // load-use, then register zero never hazards
    s = idle(); s.id_mr = 1; s.id_rt = 5; s.rs = 5;
    drive(s);
    drive(idle());
    s = idle(); s.id_mr = 1; s.id_rt = 0; s.rs = 0; s.rt = 0;
    drive(s);
    // dmem wait for 4 cycles then release
    s = idle(); s.mr = 1; s.dhit = 0;
    repeat (4) drive(s);
    s.dhit = 1;
    drive(s);
    // taken branch during an imiss
    s = idle(); s.br = 1; s.ihit = 0;
    drive(s);
    drive(idle());
    // plain halt drain into HALTED, then reset
    s = idle(); s.hlt = 1;
    drive(s);
    repeat (6) drive(idle());
    s = idle(); s.rst = 1;
    drive(s);
    // halt with a 2-cycle dmem wait mid-drain
    s = idle(); s.hlt = 1;
    drive(s);
    drive(idle());
    s = idle(); s.mw = 1; s.dhit = 0;
    repeat (2) drive(s);
    repeat (5) drive(idle());
    s = idle(); s.rst = 1;
    drive(s);
    // halt squashed by an older branch, then reset mid-drain
    s = idle(); s.hlt = 1;
    drive(s);
    s = idle(); s.br = 1;
    drive(s);
    repeat (5) drive(idle());
    s = idle(); s.hlt = 1;
    drive(s);
    drive(idle());
    s = idle(); s.rst = 1;
    drive(s);
    repeat (5) drive(idle());
    // halt held back by a load-use hazard
    s = idle(); s.hlt = 1; s.id_mr = 1; s.id_rt = 7; s.rt = 7;
    drive(s);
    s = idle(); s.hlt = 1;
    drive(s);
    repeat (5) drive(idle());

    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(99) < 3);
      s.ihit  = ($urandom_range(99) < 80);
      s.dhit  = ($urandom_range(99) < 70);
      s.mr    = ($urandom_range(99) < 20);
      s.mw    = ($urandom_range(99) < 10);
      s.br    = ($urandom_range(99) < 10);
      s.id_mr = ($urandom_range(99) < 30);
      s.hlt   = ($urandom_range(99) < 15);
      s.id_rt = 5'($urandom_range(7));
      s.rs    = 5'($urandom_range(7));
      s.rt    = 5'($urandom_range(7));
      drive(s);
    end

    repeat (3) @(posedge CLK);
    done = 1;
    @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control unit for the five-stage datapath. It drives the `WEN` (advance) and `flush` (insert NOP) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It resolves cache waits, load-use hazards and taken-branch squashes, and runs the halt-drain sequence. It observes the register outputs and hit signals and sits beside the datapath.

## Interface
Parameters:
- `DRAIN_DEPTH`, default 3: advancing cycles needed for a halt in ID to reach WB.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `CLK`  in  1  clock; every state element updates on the rising edge.
- `RST`  in  1  reset, **synchronous, active-high**.
- `ihit`  in  1  instruction fetch completed this cycle.
- `dhit`  in  1  data access completed this cycle.
- `exmem_MemRead`, `exmem_MemWrite`  in  1  memory op in MEM (EX/MEM `M_MemRead_out`/`M_MemWrite_out`).
- `exmem_branch_taken`  in  1  branch in MEM resolved taken.
- `idex_MemRead`  in  1  load in EX.
- `idex_rt`  in  5  destination of the load in EX.
- `ifid_rs`, `ifid_rt`  in  5  source registers of the instruction in ID.
- `ifid_halt`  in  1  halt opcode decoded in ID.
- `pc_WEN`  out  1  PC update enable.
- `ifid_WEN`, `idex_WEN`, `exmem_WEN`, `memwb_WEN`  out  1  register advance enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1  register clear-to-NOP.
- `halt`  out  1  registered; core halted.
- `stall_cycles`, `flush_events`  out  CNT_W  performance counters.

## Operation
- **FSM states:**
  - RUN: normal.
  - DRAIN: halt accepted; fetch frozen.
  - HALTED: pipeline frozen.
- **Registered state:** `drain_cnt`, 2 bits, saturating at `DRAIN_DEPTH`.
- **Control outputs:** combinational from state and inputs. Priority is highest first, and every output not listed defaults to WEN=1, flush=0:
  1. `RST`: all WEN=0, all flush=1, `pc_WEN`=0.
  2. HALTED: all WEN=0, all flush=0, `pc_WEN`=0.
  3. dmem wait, i.e. (`exmem_MemRead`|`exmem_MemWrite`) & !`dhit`: all WEN=0, `pc_WEN`=0. Nothing advances.
  4. Branch (`exmem_branch_taken`): `pc_WEN`=1; `ifid_flush`, `idex_flush` and `exmem_flush` are all 1. This applies regardless of `ihit`. In DRAIN it also returns the FSM to RUN and clears `drain_cnt`, because the halt was younger than the branch.
  5. Load-use: `idex_MemRead` & `idex_rt`≠0 & (`idex_rt`==`ifid_rs` | `idex_rt`==`ifid_rt`). Result: `pc_WEN`=0, `ifid_WEN`=0, `idex_flush`=1.
  6. DRAIN: `pc_WEN`=0, `ifid_flush`=1.
  7. !`ihit`: `pc_WEN`=0, `ifid_WEN`=0, `idex_flush`=1.
- **An "advancing cycle"** is any cycle in which rules 1–3 are not active.
- **Transitions:**
  - RUN→DRAIN: `ifid_halt` on an advancing cycle where rules 4, 5 and 7 are inactive. `drain_cnt` is set to 1.
  - DRAIN: `drain_cnt` increments on each advancing cycle without a branch. When it equals `DRAIN_DEPTH` on an advancing cycle, the FSM moves to HALTED.
  - HALTED is exited only by `RST`.
- **`halt`** = (state==HALTED), registered.

## Timing
- **Reset values:** state=RUN, `drain_cnt`=0, `halt`=0, counters=0. While `RST` is high the outputs follow rule 1.
- **Output latency:** control outputs settle in the same cycle as their inputs (zero latency). State updates on the next edge.
- **Load-use:** exactly one bubble per hazard. On the next cycle the load is in MEM and the hazard term is false.
- **Branch:** 3-cycle penalty. The redirected PC is written on the same edge as the squash.
- **Halt:** with no stalls, `halt` rises `DRAIN_DEPTH`+1 edges after `ifid_halt` is accepted.
- **Boundary cases:**
  - dmem wait during DRAIN: `drain_cnt` holds.
  - Reset in any state: the FSM returns to RUN on the same edge.
  - `ifid_halt` together with a load-use hazard: the halt is not accepted until the stall clears.

## Configuration
- **`PIPECTRL_PERF_EN` defined:**
  - `stall_cycles` increments on every cycle in RUN or DRAIN with `pc_WEN`=0 and `RST`=0.
  - `flush_events` increments once per cycle in which rule 4 fires.
  - Both counters wrap at 2^CNT_W, clear on `RST`, and freeze in HALTED.
- **Not defined:** both ports are tied to 0, no counter flops are built, and all other behaviour is identical.

## Test plan
- **Reset:** assert `RST` 2 cycles → all flush=1, all WEN=0, `pc_WEN`=0. After release with `ihit`=1, all WEN=1, flush=0, `halt`=0.
- **Load-use:** `idex_MemRead`=1, `idex_rt`=5, `ifid_rs`=5, `ihit`=1 → one cycle of `pc_WEN`=0, `ifid_WEN`=0, `idex_flush`=1. With `idex_rt`=0 → no stall.
- **dmem wait:** `exmem_MemRead`=1, `dhit`=0 for 4 cycles → all WEN=0 for 4 cycles. `dhit`=1 → advance. With perf enabled, `stall_cycles`=4.
- **Branch under imiss:** `exmem_branch_taken`=1 with `ihit`=0 → `pc_WEN`=1; ifid/idex/exmem flush=1; `flush_events`=1.
- **Halt:** `ifid_halt` accepted in cycle 0, no stalls → `halt`=1 after edge 4, and all WEN=0 thereafter. Inject a 2-cycle dmem wait during DRAIN → `halt` delayed by 2 cycles.
- **Halt squashed:** `ifid_halt` accepted, then `exmem_branch_taken`=1 the next cycle → FSM returns to RUN and `halt` stays 0. A later `RST` mid-DRAIN → RUN, `drain_cnt`=0.
